// File: rtl/main_mem_responder.sv
// Main-memory responder for the cache controller's main_mem_* port: line reads and
// single-word writes complete after a programmable latency with a one-cycle ready pulse.
module main_mem_responder #(
    parameter int DEPTH_LINES   = 1024,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 3,
    parameter int INIT_PATTERN  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  main_mem_addr,
    input  logic [31:0]  main_mem_data_out,
    input  logic         main_mem_read_req,
    input  logic         main_mem_write_req,
    output logic [511:0] main_mem_data_in,
    output logic         main_mem_ready,
    output logic         busy
);

    localparam int         LINE_W  = $clog2(DEPTH_LINES);
    localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

    if (DEPTH_LINES < 2 || (DEPTH_LINES & (DEPTH_LINES - 1)) != 0) begin : g_bad_depth
        $error("main_mem_responder: DEPTH_LINES must be a power of two >= 2");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 255) begin : g_bad_rd_lat
        $error("main_mem_responder: READ_LATENCY must be in 1..255");
    end
    if (WRITE_LATENCY < 1 || WRITE_LATENCY > 255) begin : g_bad_wr_lat
        $error("main_mem_responder: WRITE_LATENCY must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [LINE_W-1:0]   line_q;
    logic [3:0]          word_q;
    logic [31:0]         wdata_q;
    logic [511:0]        data_in_q;
    logic                ready_q;
    logic                busy_q;
    logic [LINE_W-1:0]   req_line;
    logic                unused_addr;

    logic [511:0]        mem_q [DEPTH_LINES];

    // Upper address bits alias onto the array; byte offset within a word is irrelevant.
    assign req_line    = main_mem_addr[6 +: LINE_W];
    assign unused_addr = ^main_mem_addr;

    if (INIT_PATTERN != 0) begin : g_init
        initial begin
            for (int i = 0; i < DEPTH_LINES; i++) begin
                mem_q[i] = 512'(unsigned'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_WRITE && cnt_q == 8'd0) begin
            mem_q[line_q][{word_q, 5'd0} +: 32] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            line_q    <= '0;
            word_q    <= 4'd0;
            wdata_q   <= 32'd0;
            data_in_q <= 512'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A simultaneous read is dropped, not queued; the initiator re-presents it.
                    if (main_mem_write_req) begin
                        line_q  <= req_line;
                        word_q  <= main_mem_addr[5:2];
                        wdata_q <= main_mem_data_out;
                        cnt_q   <= WR_LOAD;
                        state_q <= S_WRITE;
                        busy_q  <= 1'b1;
                    end else if (main_mem_read_req) begin
                        line_q  <= req_line;
                        cnt_q   <= RD_LOAD;
                        state_q <= S_READ;
                        busy_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (cnt_q == 8'd0) begin
                        data_in_q <= mem_q[line_q];
                        ready_q   <= 1'b1;
                        state_q   <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_WRITE: begin
                    if (cnt_q == 8'd0) begin
                        ready_q <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_RELEASE: begin
                    // Wait for both requests to drop so a held request is serviced once.
                    if (!main_mem_read_req && !main_mem_write_req) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign main_mem_data_in = data_in_q;
    assign main_mem_ready   = ready_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder with default parameters (1024 lines, latency 3).
module tb_main_mem_responder;

    logic         clk;
    logic         rst_n;
    logic [31:0]  main_mem_addr;
    logic [31:0]  main_mem_data_out;
    logic         main_mem_read_req;
    logic         main_mem_write_req;
    logic [511:0] main_mem_data_in;
    logic         main_mem_ready;
    logic         busy;

    int total;
    int bad;

    main_mem_responder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .main_mem_addr     (main_mem_addr),
        .main_mem_data_out (main_mem_data_out),
        .main_mem_read_req (main_mem_read_req),
        .main_mem_write_req(main_mem_write_req),
        .main_mem_data_in  (main_mem_data_in),
        .main_mem_ready    (main_mem_ready),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and step past the accept edge.
    task automatic start(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
        main_mem_addr      = a;
        main_mem_data_out  = d;
        main_mem_read_req  = r;
        main_mem_write_req = w;
        tick();
    endtask

    task automatic drop();
        main_mem_read_req  = 1'b0;
        main_mem_write_req = 1'b0;
    endtask

    // Edges after the accept edge until ready is seen (bounded).
    task automatic wait_ready(output int lat, output bit seen);
        int n;
        n    = 0;
        seen = 1'b0;
        lat  = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (main_mem_ready) begin
                seen = 1'b1;
                lat  = n;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drop();
        main_mem_addr     = 32'd0;
        main_mem_data_out = 32'd0;
        tick();
        tick();
        total++; if (main_mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", main_mem_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (main_mem_data_in !== 512'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", main_mem_data_in); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_basic();
        int lat; bit seen;
        start(32'h0000_1000, 32'd0, 1'b1, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy_after_accept got=%0b exp=1", busy); end
        total++; if (main_mem_ready !== 1'b0) begin bad++; $display("FAIL rd_early_ready got=%0b exp=0", main_mem_ready); end
        drop();
        wait_ready(lat, seen);
        total++; if (!seen || lat != 3) begin bad++; $display("FAIL rd_latency got=%0d seen=%0b exp=3", lat, seen); end
        total++; if (main_mem_data_in !== 512'd64) begin bad++; $display("FAIL rd_data got=%0h exp=40", main_mem_data_in); end
        tick();
        total++; if (main_mem_ready !== 1'b0) begin bad++; $display("FAIL rd_pulse_width got=%0b exp=0", main_mem_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_release got=%0b exp=0", busy); end
        total++; if (main_mem_data_in !== 512'd64) begin bad++; $display("FAIL rd_data_hold got=%0h exp=40", main_mem_data_in); end
    endtask

    task automatic test_write_then_read();
        int lat; bit seen;
        logic [511:0] exp;
        start(32'h0000_2008, 32'hCAFE_BABE, 1'b0, 1'b1);
        drop();
        wait_ready(lat, seen);
        total++; if (!seen || lat != 3) begin bad++; $display("FAIL wr_latency got=%0d seen=%0b exp=3", lat, seen); end
        total++; if (main_mem_data_in !== 512'd64) begin bad++; $display("FAIL wr_data_in_untouched got=%0h exp=40", main_mem_data_in); end
        tick();
        start(32'h0000_2000, 32'd0, 1'b1, 1'b0);
        drop();
        wait_ready(lat, seen);
        exp = 512'd128;
        exp[64 +: 32] = 32'hCAFE_BABE;
        total++; if (!seen || main_mem_data_in !== exp) begin bad++; $display("FAIL wr_readback got=%0h exp=%0h", main_mem_data_in, exp); end
        tick();
    endtask

    task automatic test_held_read();
        int pulses;
        pulses = 0;
        main_mem_addr      = 32'h0000_0040;
        main_mem_read_req  = 1'b1;
        main_mem_write_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (main_mem_ready) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_busy got=%0b exp=1", busy); end
        total++; if (main_mem_data_in !== 512'd1) begin bad++; $display("FAIL held_data got=%0h exp=1", main_mem_data_in); end
        drop();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_release_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_both_req();
        int pulses; int lat; bit seen;
        pulses = 0;
        start(32'h0000_0080, 32'h1234_5678, 1'b1, 1'b1);
        drop();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (main_mem_ready) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL both_pulses got=%0d exp=1", pulses); end
        total++; if (main_mem_data_in !== 512'd1) begin bad++; $display("FAIL both_no_read got=%0h exp=1", main_mem_data_in); end
        start(32'h0000_0080, 32'd0, 1'b1, 1'b0);
        drop();
        wait_ready(lat, seen);
        total++; if (!seen || main_mem_data_in !== 512'h1234_5678) begin bad++; $display("FAIL both_readback got=%0h exp=12345678", main_mem_data_in); end
        tick();
    endtask

    task automatic test_reset_mid_write();
        int pulses; int lat; bit seen;
        pulses = 0;
        start(32'h0000_00C0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drop();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (main_mem_ready) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (main_mem_ready) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_ready got=%0d exp=0", pulses); end
        start(32'h0000_00C0, 32'd0, 1'b1, 1'b0);
        drop();
        wait_ready(lat, seen);
        total++; if (!seen || main_mem_data_in !== 512'd3) begin bad++; $display("FAIL rstmid_line3 got=%0h exp=3", main_mem_data_in); end
        tick();
    endtask

    task automatic test_alias();
        int lat; bit seen;
        start(32'h0001_0040, 32'd0, 1'b1, 1'b0);
        drop();
        wait_ready(lat, seen);
        total++; if (!seen || main_mem_data_in !== 512'd1) begin bad++; $display("FAIL alias_line1 got=%0h exp=1", main_mem_data_in); end
        tick();
        start(32'h0000_FFC3, 32'd0, 1'b1, 1'b0);
        drop();
        wait_ready(lat, seen);
        total++; if (!seen || main_mem_data_in !== 512'd1023) begin bad++; $display("FAIL last_line got=%0h exp=3ff", main_mem_data_in); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_read_basic();
        test_write_then_read();
        test_held_read();
        test_both_req();
        test_reset_mid_write();
        test_alias();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
